button_operand_sequencer: RTL

BUTTON_OPERAND_SEQUENCER -- requirements
Module: button_operand_sequencer

---
 rtl/button_operand_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/button_operand_sequencer.sv
// Debounced push-button that steps through a fixed table of IEEE-754 operand pairs
// for a downstream FP adder, emitting a one-cycle strobe on every accepted press.
module button_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  output logic [31:0] reg_A,
  output logic [31:0] reg_B,
  output logic        operand_valid,
  output logic [7:0]  press_count,
  output logic [2:0]  pair_index
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             accept;
  logic             btn_meta, btn_sync;
  logic [2:0]       pair_nxt;

  function automatic logic [63:0] operand_lookup(input logic [2:0] idx);
    logic [63:0] ab;
    case (idx)
      3'd0:    ab = {32'h3F800000, 32'h40000000};
      3'd1:    ab = {32'h40490FDB, 32'hC0490FDB};
      3'd2:    ab = {32'h7F800000, 32'h3F800000};
      3'd3:    ab = {32'h00000001, 32'h00000001};
      3'd4:    ab = {32'h7F7FFFFF, 32'h7F7FFFFF};
      3'd5:    ab = {32'h7FC00000, 32'h3F800000};
      3'd6:    ab = {32'h80000000, 32'h00000000};
      default: ab = {32'h3F800000, 32'hBF800000};
    endcase
    return ab;
  endfunction

  // Stage: two-flop synchroniser for the asynchronous button level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
    end
  end

  // Stage: debounce FSM, a level change needs DEBOUNCE_CYCLES+1 agreeing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_nxt = PRESS_WAIT;
          count_nxt = CNT_W'(1);
        end else begin
          count_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (count == CNT_MAX) begin
          state_nxt = PRESSED;
          count_nxt = '0;
          accept    = 1'b1;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_nxt = RELEASE_WAIT;
          count_nxt = CNT_W'(1);
        end else begin
          count_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_nxt = PRESSED;
          count_nxt = '0;
        end else if (count == CNT_MAX) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  assign pair_nxt = pair_index + 3'd1;

  // Stage: operand registers, all updated together on the accepting edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_index    <= 3'd0;
      reg_A         <= 32'h3F800000;
      reg_B         <= 32'h40000000;
      press_count   <= 8'd0;
      operand_valid <= 1'b0;
    end else begin
      operand_valid <= accept;
      if (accept) begin
        pair_index     <= pair_nxt;
        {reg_A, reg_B} <= operand_lookup(pair_nxt);
        press_count    <= press_count + 8'd1;
      end
    end
  end

endmodule
